// File: rtl/lut_mem_pkg.sv
// rtl/lut_mem_pkg.sv - shared bus widths and the packed bus record for the lut_mem chain
package lut_mem_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    // One transaction as it travels between stages.
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_DATA_W-1:0] rdata;
        logic                  rw;
        logic                  valid;
    } bus_t;

    localparam bus_t BUS_IDLE = '0;

endpackage

// File: rtl/lut_mem_bus_reg.sv
// rtl/lut_mem_bus_reg.sv - resettable one-cycle pipeline register for a bus_t record
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset; clears the whole record (valid included)
//   d_i  - next-cycle bus value
//   q_o  - registered bus value
module lut_mem_bus_reg
    import lut_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  bus_t d_i,
    output bus_t q_o
);

    bus_t bus_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= BUS_IDLE;
        end else begin
            bus_q <= d_i;
        end
    end

    assign q_o = bus_q;

endmodule

// File: rtl/lut_mem.sv
// rtl/lut_mem.sv - chainable lookup-table stage: decodes an address window, serves or captures data, registers the bus
//
// Parameters:
//   DEPTH     - number of 16-bit words held by this stage
//   BASE_ADDR - first bus address decoded by this stage
//
// Ports:
//   clk, rst                   - clock and synchronous active-high reset
//   addr_i, wdata_i, rdata_i   - upstream bus address / write data / read data
//   rw_i, valid_i              - upstream direction (1 = write) and valid
//   addr_o, wdata_o, rdata_o   - registered bus toward downstream
//   rw_o, valid_o              - registered direction and valid toward downstream
//
// Configuration:
//   LUT_MEM_WRITE_EN - when defined, write hits update mem; otherwise the stage is read-only.
module lut_mem
    import lut_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] addr_i,
    input  logic [BUS_DATA_W-1:0] wdata_i,
    input  logic [BUS_DATA_W-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [BUS_ADDR_W-1:0] addr_o,
    output logic [BUS_DATA_W-1:0] wdata_o,
    output logic [BUS_DATA_W-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o
);

`ifdef LUT_MEM_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BUS_DATA_W-1:0] mem [DEPTH];

    logic [31:0]      addr_ext;
    logic [31:0]      offset;
    logic             in_win;
    logic             rd_hit;
    logic             wr_hit;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    bus_t             bus_d;
    bus_t             bus_q;

    // The window compare is done at 32 bits so BASE_ADDR + DEPTH may reach 65536
    // without the upper bound wrapping back to zero.
    assign addr_ext = {16'b0, addr_i};
    assign offset   = addr_ext - BASE_ADDR;
    assign in_win   = (addr_ext >= BASE_ADDR) && (offset < DEPTH);
    assign idx      = offset[IDX_W-1:0];

    assign rd_hit = valid_i && in_win && !rw_i;
    assign wr_hit = valid_i && in_win &&  rw_i;

    // A write that coincides with reset is dropped along with the rest of the cycle.
    assign wr_en = WRITE_EN && wr_hit && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata_i;
        end
    end

    // Only a read hit replaces the upstream read data; writes and misses pass it through.
    always_comb begin
        bus_d       = BUS_IDLE;
        bus_d.addr  = addr_i;
        bus_d.wdata = wdata_i;
        bus_d.rw    = rw_i;
        bus_d.valid = valid_i;
        bus_d.rdata = rdata_i;
        if (rd_hit) begin
            bus_d.rdata = mem[idx];
        end
    end

    lut_mem_bus_reg u_bus_reg (
        .clk (clk),
        .rst (rst),
        .d_i (bus_d),
        .q_o (bus_q)
    );

    assign addr_o  = bus_q.addr;
    assign wdata_o = bus_q.wdata;
    assign rdata_o = bus_q.rdata;
    assign rw_o    = bus_q.rw;
    assign valid_o = bus_q.valid;

endmodule

// File: tb/tb_lut_mem.sv
// tb/tb_lut_mem.sv - three-stage lut_mem chain checked against a flat-address reference model
module tb_lut_mem;
    import lut_mem_pkg::*;

`ifdef LUT_MEM_WRITE_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    localparam int TOTAL = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] s_addr  [4];
    logic [15:0] s_wdata [4];
    logic [15:0] s_rdata [4];
    logic        s_rw    [4];
    logic        s_valid [4];

    lut_mem #(.DEPTH(8), .BASE_ADDR(0)) u0 (
        .clk(clk), .rst(rst),
        .addr_i(s_addr[0]), .wdata_i(s_wdata[0]), .rdata_i(s_rdata[0]), .rw_i(s_rw[0]), .valid_i(s_valid[0]),
        .addr_o(s_addr[1]), .wdata_o(s_wdata[1]), .rdata_o(s_rdata[1]), .rw_o(s_rw[1]), .valid_o(s_valid[1])
    );
    lut_mem #(.DEPTH(8), .BASE_ADDR(8)) u1 (
        .clk(clk), .rst(rst),
        .addr_i(s_addr[1]), .wdata_i(s_wdata[1]), .rdata_i(s_rdata[1]), .rw_i(s_rw[1]), .valid_i(s_valid[1]),
        .addr_o(s_addr[2]), .wdata_o(s_wdata[2]), .rdata_o(s_rdata[2]), .rw_o(s_rw[2]), .valid_o(s_valid[2])
    );
    lut_mem #(.DEPTH(8), .BASE_ADDR(16)) u2 (
        .clk(clk), .rst(rst),
        .addr_i(s_addr[2]), .wdata_i(s_wdata[2]), .rdata_i(s_rdata[2]), .rw_i(s_rw[2]), .valid_i(s_valid[2]),
        .addr_o(s_addr[3]), .wdata_o(s_wdata[3]), .rdata_o(s_rdata[3]), .rw_o(s_rw[3]), .valid_o(s_valid[3])
    );

    // Reference: one flat 24-word space; a transaction emerges 3 cycles after it is presented.
    logic [15:0] ref_mem [TOTAL];
    bus_t        expq [$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_bus(input string tag, input bus_t e);
        chk({tag, "_addr"},  s_addr[3],         e.addr);
        chk({tag, "_wdata"}, s_wdata[3],        e.wdata);
        chk({tag, "_rdata"}, s_rdata[3],        e.rdata);
        chk({tag, "_rw"},    {15'b0, s_rw[3]},  {15'b0, e.rw});
        chk({tag, "_valid"}, {15'b0, s_valid[3]}, {15'b0, e.valid});
    endtask

    task automatic chk_mems(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_m0_%0d", tag, i), u0.mem[i], ref_mem[i]);
            chk($sformatf("%s_m1_%0d", tag, i), u1.mem[i], ref_mem[8 + i]);
            chk($sformatf("%s_m2_%0d", tag, i), u2.mem[i], ref_mem[16 + i]);
        end
    endtask

    // Present one cycle of stimulus, advance one clock, and check whatever is due at the chain output.
    task automatic drive(input bit r, input bit v, input bit w,
                         input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd);
        bus_t e;
        rst        = r;
        s_addr[0]  = a;
        s_wdata[0] = wd;
        s_rdata[0] = rd;
        s_rw[0]    = w;
        s_valid[0] = v;
        if (!r) begin
            e.addr  = a;
            e.wdata = wd;
            e.rdata = rd;
            e.rw    = w;
            e.valid = v;
            if (v && a < TOTAL) begin
                if (!w) e.rdata = ref_mem[a];
                else if (WEN) ref_mem[a] = wd;
            end
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            chk_bus("reset", BUS_IDLE);
            expq.delete();
            expq.push_back(BUS_IDLE);
            expq.push_back(BUS_IDLE);
        end else if (expq.size() == 3) begin
            e = expq.pop_front();
            chk_bus("out", e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            u0.mem[i] <= 16'(i);
            u1.mem[i] <= 16'(8 + i);
            u2.mem[i] <= 16'(16 + i);
        end
        for (int i = 0; i < TOTAL; i++) ref_mem[i] = 16'(i);

        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        // Read inside the first stage.
        drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000);
        idle(2);
        chk("req028_valid", {15'b0, s_valid[3]}, 16'h0001);
        chk("req028_addr",  s_addr[3],  16'h0001);
        chk("req028_rdata", s_rdata[3], 16'h0001);
        idle(1);

        // Read inside the third stage.
        drive(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0000);
        idle(2);
        chk("req029_rdata", s_rdata[3], 16'h0012);
        idle(1);

        // Write then read back in the third stage.
        drive(1'b0, 1'b1, 1'b1, 16'h0012, 16'h0069, 16'h0000);
        idle(2);
        chk("req030_rw",    {15'b0, s_rw[3]}, 16'h0001);
        chk("req030_rdata", s_rdata[3], 16'h0000);
        chk("req030_mem2",  u2.mem[2], WEN ? 16'h0069 : 16'h0012);
        chk_mems("req030");
        drive(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0000);
        idle(2);
        chk("req031_rdata", s_rdata[3], WEN ? 16'h0069 : 16'h0012);

        // Out-of-range read and window boundaries, back to back.
        drive(1'b0, 1'b1, 1'b0, 16'h0018, 16'h0000, 16'hBEEF);
        drive(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h0000);
        chk("req032_miss", s_rdata[3], 16'hBEEF);
        idle(1);
        chk("req032_lo", s_rdata[3], 16'h0007);
        idle(1);
        chk("req032_hi", s_rdata[3], 16'h0008);
        drive(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h1234, 16'h5A5A);
        idle(3);

        // Reset with a read in flight and a write presented during reset.
        drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 16'h0003, 16'hDEAD, 16'h0000);
        chk("req033_valid", {15'b0, s_valid[3]}, 16'h0000);
        idle(3);
        drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000);
        idle(1);
        chk("req033_rd1", s_rdata[3], 16'h0001);
        idle(1);
        chk("req033_rd3", s_rdata[3], 16'h0003);
        idle(1);

        // Randomised traffic, mostly inside or just past the 24-word space.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
            drive($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom),
                  a, 16'($urandom), 16'($urandom));
        end
        idle(3);
        chk_mems("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lut_mem.md
LUT_MEM -- requirements
Module: lut_mem

Interface
REQ-001 Parameter DEPTH, default 8: number of 16-bit words held by this stage.
REQ-002 Parameter BASE_ADDR, default 0: first bus address decoded by this stage.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 addr_i  input  16: bus address from upstream.
REQ-006 wdata_i  input  16: write data from upstream.
REQ-007 rdata_i  input  16: read data from upstream.
REQ-008 rw_i  input  1: 1 = write, 0 = read.
REQ-009 valid_i  input  1: upstream transaction valid for this cycle.
REQ-010 addr_o, wdata_o, rdata_o  output  16 each: registered bus toward downstream.
REQ-011 rw_o, valid_o  output  1 each: registered rw and valid toward downstream.

Function
REQ-012 Storage SHALL be an array named mem, DEPTH x 16 bits, hierarchically accessible as <inst>.mem[i] for bench preload.
REQ-013 Every cycle, addr_o, wdata_o, rw_o and valid_o SHALL take addr_i, wdata_i, rw_i and valid_i, registered; latency exactly 1 cycle per stage, no backpressure.
REQ-014 Hit: valid_i=1 and BASE_ADDR <= addr_i <= BASE_ADDR+DEPTH-1 (inclusive both ends); local index = addr_i - BASE_ADDR.
REQ-015 Read hit (rw_i=0): rdata_o SHALL be mem[index] on the next cycle.
REQ-016 Write hit (rw_i=1): mem[index] SHALL take wdata_i at the same edge; rdata_o SHALL take rdata_i.
REQ-017 Miss or valid_i=0: rdata_o SHALL take rdata_i; mem unchanged.
REQ-018 Address compare SHALL be computed at 17 bits or wider, so BASE_ADDR+DEPTH up to 65536 never wraps.
REQ-019 Transactions may arrive every cycle back-to-back; each is handled independently with no internal state beyond mem and the output registers.
REQ-020 Stages SHALL chain (one stage's outputs drive the next stage's inputs) with non-overlapping address windows; chain latency = number of stages.

Reset
REQ-021 When rst=1 at a rising edge, all outputs SHALL become 0 on that edge, including valid_o.
REQ-022 Reset SHALL NOT clear mem; a write presented in the same cycle as rst=1 SHALL be dropped.
REQ-023 Reset mid-transaction drops the in-flight transaction; the first valid_o after rst falls corresponds to a post-reset valid_i.

Configuration
REQ-024 Macro LUT_MEM_WRITE_EN: when defined, write hits update mem per REQ-016.
REQ-025 Without LUT_MEM_WRITE_EN the stage SHALL be read-only: write hits leave mem unchanged; passthrough as REQ-016; reads unchanged.

Structure
REQ-026 Package lut_mem_pkg SHALL hold BUS_ADDR_W=16, BUS_DATA_W=16 and a packed typedef bus_t {addr, wdata, rdata, rw, valid}.
REQ-027 One sub-module, lut_mem_bus_reg, SHALL implement the resettable bus_t pipeline register; lut_mem instantiates it and adds decode and storage.

Verification
Bench setup: three stages, DEPTH=8, BASE_ADDR 0/8/16, mem[i] preloaded with BASE_ADDR+i, LUT_MEM_WRITE_EN defined; responses checked at the last stage's outputs.
REQ-028 Read 0x0001 for one cycle -> 3 cycles later valid_o=1, addr_o=0x0001, rdata_o=0x0001.
REQ-029 Read 0x0012 -> rdata_o=0x0012 after 3 cycles.
REQ-030 Write 0x0012 with 0x0069 -> third stage mem[2]=0x0069; all other words unchanged; rw_o=1; rdata_o=0.
REQ-031 Then read 0x0012 -> rdata_o=0x0069.
REQ-032 Read 0x0018 (out of range) with rdata_i=0xBEEF -> rdata_o=0xBEEF; boundary reads 0x0007/0x0008 return 0x0007/0x0008.
REQ-033 Assert rst while a read of 0x0001 is in flight -> all outputs 0 the next cycle; mem contents intact on later reads.
